key_conditioner: RTL

Input-side companion to the LED/light controllers on the DE-board. It synchronises and debounces the active-low KEY push-buttons and emits clean one-cycle press and release events plus a stable level per key. Light and speed controllers consume these events, so they no longer need ad-hoc "block" flags.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_conditioner_if.sv | 12 +
 rtl/key_debounce_channel.sv | 97 +++++++++
 rtl/key_conditioner.sv | 37 +++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and types for the key conditioner and its per-key channel.
package key_pkg;

    localparam logic KEY_PRESSED = 1'b0;  // raw KEY polarity
    localparam int   DEBOUNCE_W  = 24;
    localparam int   REPEAT_W    = 32;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } key_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle of the raw KEY inputs and the conditioned level/press/release outputs.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] KEY;
    logic [NUM_KEYS-1:0] KEY_LEVEL;
    logic [NUM_KEYS-1:0] KEY_PRESS;
    logic [NUM_KEYS-1:0] KEY_RELEASE;

    modport master (output KEY, input KEY_LEVEL, input KEY_PRESS, input KEY_RELEASE);
    modport slave  (input KEY, output KEY_LEVEL, output KEY_PRESS, output KEY_RELEASE);
endinterface

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, debounce counter/FSM, optional auto-repeat.
// Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 6250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= 2**DEBOUNCE_W ||
        REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("key_debounce_channel: illegal parameter set");
    end

    logic [1:0]            sync_q;
    key_state_t            state_q, state_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  press_q, release_q;
    logic                  acc_press, acc_release, rpt_fire;
    logic                  stable_pressed, sync_pressed;

    assign stable_pressed = (state_q == PRESSED) || (state_q == RELEASE_PENDING);
    assign sync_pressed   = (sync_q[1] == KEY_PRESSED);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_press   = 1'b0;
        acc_release = 1'b0;
        if (sync_pressed == stable_pressed) begin
            cnt_d   = '0;
            state_d = stable_pressed ? PRESSED : RELEASED;
        end else if (cnt_q == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d       = '0;
            state_d     = sync_pressed ? PRESSED : RELEASED;
            acc_press   = sync_pressed;
            acc_release = ~sync_pressed;
        end else begin
            cnt_d   = cnt_q + DEBOUNCE_W'(1);
            state_d = stable_pressed ? RELEASE_PENDING : PRESS_PENDING;
        end
    end

`ifdef KEY_REPEAT_EN
    logic [REPEAT_W-1:0] rpt_q, rpt_d;

    // Reload to DELAY-PERIOD so the same terminal compare spaces later repeats by PERIOD.
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (stable_pressed && !acc_release) begin
            if (rpt_q == REPEAT_W'(REPEAT_DELAY - 1)) begin
                rpt_fire = 1'b1;
                rpt_d    = REPEAT_W'(REPEAT_DELAY - REPEAT_PERIOD);
            end else begin
                rpt_d = rpt_q + REPEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rpt_q <= '0;
        else         rpt_q <= rpt_d;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q    <= {2{~KEY_PRESSED}};
            state_q   <= RELEASED;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= acc_press | rpt_fire;
            release_q <= acc_release;
        end
    end

    assign level_o   = stable_pressed;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounced KEY front end: NUM_KEYS independent channels.
// Optional auto-repeat on KEY_PRESS when KEY_REPEAT_EN is defined.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 6250000
) (
    input  logic           CLOCK_50,
    input  logic           RESET_N,
    key_conditioner_if.slave kif
);

    logic [NUM_KEYS-1:0] level, press, rel;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i     (CLOCK_50),
            .rst_ni    (RESET_N),
            .key_i     (kif.KEY[g]),
            .level_o   (level[g]),
            .press_o   (press[g]),
            .release_o (rel[g])
        );
    end

    assign kif.KEY_LEVEL   = level;
    assign kif.KEY_PRESS   = press;
    assign kif.KEY_RELEASE = rel;

endmodule
